bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double-dabble), one bit per clock.
- Sits directly downstream of the 8-bit up/down loadable counter `count_8`.
- Takes the counter's `out` value and produces packed BCD digits for the display stage.
- Start/busy/done handshake; the result is held stable between conversions.

Parameters:
- WIDTH, 8, width of binary input (matches `count_8` out).
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH-1; there is no overflow handling.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a conversion; sampled only in IDLE
- bin  input  WIDTH  binary value, captured on the accepting edge
- busy  output  1  high while a conversion is in progress (SHIFT or DONE)
- done  output  1  one-cycle pulse; bcd is valid and updated
- bcd  output  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0]

Behaviour:
- Interface, as decided: one clock; reset is synchronous and active-high. Clock port is `clk`, reset port is `rst`.
- Reset: on an edge with rst=1:
  - state=IDLE; bcd=0, busy=0, done=0; internal shift register and counter cleared.
  - rst has priority over all other inputs in every state, including mid-conversion. No done pulse is emitted for an aborted conversion.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: load the scratch register {DIGITS*4 zeros, bin}, set iteration counter=0, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT:
  - busy=1. Each edge performs one iteration:
    - every BCD nibble >=5 gets +3 (all nibbles in parallel, using the pre-shift values);
    - then the whole scratch register shifts left by 1;
    - counter increments.
  - On the edge completing iteration WIDTH: write the BCD field to bcd, go to DONE.
- DONE:
  - busy=1, done=1 for exactly one cycle.
  - Next edge returns to IDLE. start is not accepted in DONE.
- Latency:
  - start accepted at edge E0; done high in the cycle after edge E0+WIDTH; bcd updates at that same edge.
  - Back-to-back throughput is one conversion per WIDTH+2 cycles when start is held high.
- start or bin changes while busy=1 are ignored; the value captured at E0 is the one converted.
- bcd holds the last completed result until the next completion or reset. It never shows intermediate values.
- done and busy are registered outputs (no combinational path from inputs).
- Iteration counter width is clog2(WIDTH+1). Nibble add-3 is 4-bit, with no carry out of the nibble.

Optional Feature:
- Macro: BCD_BLANK_EN
- Defined:
  - Extra output port `blank`, width DIGITS, registered and updated together with bcd.
  - blank[i]=1 when digit i and all digits above it are zero (leading-zero blanking). blank[0] is always 0.
  - Reset value is {DIGITS-1 ones, 0}.
- Undefined: the port and its logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 edges, with start=1 and bin=8'hFF driven -> bcd=12'h000, busy=0, done=0 throughout; no conversion begins.
- Single conversion: bin=8'h26, start pulsed for 1 cycle ->
  - busy=1 for 9 cycles;
  - done high for exactly one cycle, 8 edges after the accept edge;
  - bcd=12'h038.
- Boundaries and sweep:
  - bin=0 -> 12'h000; bin=255 -> 12'h255; bin=99 -> 12'h099; bin=100 -> 12'h100.
  - Exhaustive 0..255, driven from a `count_8` instance counting up, with each bcd checked against a div/mod-10 model.
- Hold start high while bin changes every cycle:
  - each result equals the bin value at its accept edge;
  - done pulses are spaced 10 cycles apart;
  - bcd is stable between pulses.
- Reset mid-operation: start with bin=200, assert rst after 4 SHIFT edges ->
  - next cycle busy=0, bcd=0, and no done pulse ever appears;
  - a new start with bin=5 yields 12'h005.
- With BCD_BLANK_EN: bin=7 -> blank=3'b110; bin=0 -> 3'b110; bin=42 -> 3'b100; bin=100 -> 3'b000. After reset -> 3'b110.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one bit per clock, with start/busy/done handshake.
// Optional leading-zero blanking output `blank` is built when BCD_BLANK_EN is defined.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int SW = 4 * DIGITS + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]          r_state;
    logic [SW-1:0]       r_scratch;
    logic [CW-1:0]       r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [4*DIGITS-1:0] r_bcd;

    logic [SW-1:0]       w_adj;
    logic [SW-1:0]       w_shifted;
    logic [4*DIGITS-1:0] w_bcd_new;
    logic                w_last;

    // Binary part passes through; each BCD nibble is corrected before the shift.
    assign w_adj[WIDTH-1:0] = r_scratch[WIDTH-1:0];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            logic [3:0] w_nib;
            assign w_nib = r_scratch[WIDTH+4*gi +: 4];
            assign w_adj[WIDTH+4*gi +: 4] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
        end
    endgenerate

    assign w_shifted = w_adj << 1;
    assign w_bcd_new = w_shifted[SW-1:WIDTH];
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] r_blank;
    logic [DIGITS-1:0] w_blank_new;
    logic [DIGITS-1:0] w_zero;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_zero
            assign w_zero[gi] = (w_bcd_new[4*gi +: 4] == 4'd0);
        end
        // The units digit is always shown, so blank[0] stays low.
        assign w_blank_new[0] = 1'b0;
        for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
            assign w_blank_new[gi] = &w_zero[DIGITS-1:gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blank <= {DIGITS{1'b1}} << 1;
        end else if (r_state == S_SHIFT && w_last) begin
            r_blank <= w_blank_new;
        end
    end

    assign blank = r_blank;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_scratch <= {{(4*DIGITS){1'b0}}, bin};
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_scratch <= w_shifted;
                    r_cnt     <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_bcd   <= w_bcd_new;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;

endmodule
